decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 130 +++++++++++++
 tb/tb_decode_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: 32x32 register file plus a one-entry output register with
// writeback bypass at capture and writeback snooping while a bundle is stalled.
module decode_stage (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               wb_en,
  input  logic [4:0]         wb_rd,
  input  logic [31:0]        wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6:0]         opcode,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [4:0]         rd,
  output logic signed [31:0] read_data1,
  output logic signed [31:0] read_data2,
  output logic signed [31:0] imm,
  output logic               illegal
);
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [31:0] r_rf [32];
  logic        r_valid, r_illegal;
  logic [6:0]  r_opcode, r_funct7;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd, r_rs1, r_rs2;
  logic [31:0] r_rd1, r_rd2, r_imm;

  logic        w_wr, w_cap, w_illegal;
  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1, w_rs2;
  logic [31:0] w_op1, w_op2, w_imm;

  assign w_op  = instr[6:0];
  assign w_f3  = instr[14:12];
  assign w_f7  = instr[31:25];
  assign w_rs1 = instr[19:15];
  assign w_rs2 = instr[24:20];

  assign w_wr     = wb_en && (wb_rd != 5'd0);
  assign in_ready = rst_n && (!r_valid || out_ready);
  assign w_cap    = in_valid && in_ready;

  // Operand read with same-edge writeback forwarding.
  assign w_op1 = (w_rs1 == 5'd0) ? 32'd0 : (w_wr && wb_rd == w_rs1) ? wb_data : r_rf[w_rs1];
  assign w_op2 = (w_rs2 == 5'd0) ? 32'd0 : (w_wr && wb_rd == w_rs2) ? wb_data : r_rf[w_rs2];

  always_comb begin
    w_illegal = 1'b1;
    w_imm     = 32'd0;
    case (w_op)
      OP_IMM: begin
        w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
        w_imm     = {{20{instr[31]}}, instr[31:20]};
      end
      OP_LOAD: begin
        w_illegal = (w_f3 != 3'b010);
        w_imm     = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        w_illegal = (w_f3 != 3'b010);
        w_imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_REG: begin
        w_illegal = !(((w_f7 == 7'b0000000) && (w_f3 != 3'b010) && (w_f3 != 3'b011)) ||
                      ((w_f7 == 7'b0100000) && (w_f3 == 3'b000)));
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
    end else if (w_wr) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_opcode  <= 7'd0;
      r_funct3  <= 3'd0;
      r_funct7  <= 7'd0;
      r_rd      <= 5'd0;
      r_rs1     <= 5'd0;
      r_rs2     <= 5'd0;
      r_rd1     <= 32'd0;
      r_rd2     <= 32'd0;
      r_imm     <= 32'd0;
    end else if (w_cap) begin
      r_valid   <= 1'b1;
      r_illegal <= w_illegal;
      r_opcode  <= w_op;
      r_funct3  <= w_f3;
      r_funct7  <= w_f7;
      r_rd      <= instr[11:7];
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_rd1     <= w_illegal ? 32'd0 : w_op1;
      r_rd2     <= w_illegal ? 32'd0 : w_op2;
      r_imm     <= w_illegal ? 32'd0 : w_imm;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end else if (r_valid && !r_illegal && w_wr) begin
      // Held bundle tracks writes so it never leaves with stale operands.
      if (wb_rd == r_rs1) r_rd1 <= wb_data;
      if (wb_rd == r_rs2) r_rd2 <= wb_data;
    end
  end

  assign out_valid  = r_valid;
  assign opcode     = r_opcode;
  assign funct3     = r_funct3;
  assign funct7     = r_funct7;
  assign rd         = r_rd;
  assign read_data1 = r_rd1;
  assign read_data2 = r_rd2;
  assign imm        = r_imm;
  assign illegal    = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, stall/reset sequences and
// randomized traffic checked against a behavioural model of the stage.
module tb_decode_stage;
  logic               clk = 1'b0;
  logic               rst_n;
  logic [31:0]        instr;
  logic               in_valid, in_ready;
  logic               wb_en;
  logic [4:0]         wb_rd;
  logic [31:0]        wb_data;
  logic               out_valid, out_ready;
  logic [6:0]         opcode, funct7;
  logic [2:0]         funct3;
  logic [4:0]         rd;
  logic signed [31:0] read_data1, read_data2, imm;
  logic               illegal;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
    .read_data1(read_data1), .read_data2(read_data2), .imm(imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] rd1, rd2, imm;
    logic        ill;
  } bund_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic        ill;
    logic [31:0] rd1, rd2;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rf [32];
  logic        m_valid, m_cmp;
  logic [31:0] m_instr;
  bund_t       m_b;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask

  function automatic bit legal(input logic [31:0] w);
    int f3 = int'(w[14:12]);
    case (w[6:0])
      7'h13:        return !(f3 == 2 || f3 == 3);
      7'h33:        return (w[31:25] == 7'h00 && !(f3 == 2 || f3 == 3)) ||
                           (w[31:25] == 7'h20 && f3 == 0);
      7'h03, 7'h23: return f3 == 2;
      default:      return 0;
    endcase
  endfunction

  function automatic logic [31:0] regval(input logic [4:0] r);
    if (r == 0) return 0;
    if (wb_en && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic bund_t predict(input logic [31:0] w);
    bund_t b;
    int    s;
    b = '0;
    b.op = w[6:0]; b.f3 = w[14:12]; b.f7 = w[31:25]; b.rd = w[11:7];
    b.ill = !legal(w);
    if (!b.ill) begin
      b.rd1 = regval(w[19:15]);
      b.rd2 = regval(w[24:20]);
      if (w[6:0] == 7'h13 || w[6:0] == 7'h03) begin
        s = $signed(w[31:20]);
        b.imm = s;
      end else if (w[6:0] == 7'h23) begin
        s = $signed({w[31:25], w[11:7]});
        b.imm = s;
      end
    end
    return b;
  endfunction

  // One clock: check in_ready, advance the model, then check outputs.
  task automatic tick();
    bit cap;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rst_n && (!m_valid || out_ready)});
    if (!rst_n) begin
      m_valid = 0; m_cmp = 1; m_b = '0; m_instr = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      cap = in_valid && (!m_valid || out_ready);
      if (cap) begin
        m_b = predict(instr); m_instr = instr; m_valid = 1; m_cmp = 1;
      end else if (out_ready) begin
        m_valid = 0; m_cmp = 0;
      end else if (m_valid && !m_b.ill && wb_en && wb_rd != 0) begin
        if (wb_rd == m_instr[19:15]) m_b.rd1 = wb_data;
        if (wb_rd == m_instr[24:20]) m_b.rd2 = wb_data;
      end
      if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_cmp) begin
      chk("opcode", {25'd0, opcode}, {25'd0, m_b.op});
      chk("funct3", {29'd0, funct3}, {29'd0, m_b.f3});
      chk("funct7", {25'd0, funct7}, {25'd0, m_b.f7});
      chk("rd", {27'd0, rd}, {27'd0, m_b.rd});
      chk("read_data1", read_data1, m_b.rd1);
      chk("read_data2", read_data2, m_b.rd2);
      chk("imm", imm, m_b.imm);
      chk("illegal", {31'd0, illegal}, {31'd0, m_b.ill});
    end
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1; wb_rd = r; wb_data = d;
    tick();
    wb_en = 0;
  endtask

  vec_t tbl [12];
  logic [6:0] ops [5];

  initial begin
    tbl[0]  = '{32'hFFD28313, 32'hFFFFFFFD, 0, 32'h10,  32'h0};   // ADDI x6,x5,-3
    tbl[1]  = '{32'hFE712C23, 32'hFFFFFFF8, 0, 32'h100, 32'hAB};  // SW x7,-8(x2)
    tbl[2]  = '{32'h004180B3, 32'h0,        0, 32'h0,   32'h22};  // ADD x1,x3,x4
    tbl[3]  = '{32'h0000007F, 32'h0,        1, 32'h0,   32'h0};   // unknown opcode
    tbl[4]  = '{32'h40004033, 32'h0,        1, 32'h0,   32'h0};   // SUB with funct3=100
    tbl[5]  = '{32'h00412083, 32'h4,        0, 32'h100, 32'h22};  // LW x1,4(x2)
    tbl[6]  = '{32'h00010083, 32'h0,        1, 32'h0,   32'h0};   // LB
    tbl[7]  = '{32'h00002013, 32'h0,        1, 32'h0,   32'h0};   // SLTI
    tbl[8]  = '{32'h7FF00013, 32'h7FF,      0, 32'h0,   32'h0};   // ADDI max imm
    tbl[9]  = '{32'h40005033, 32'h0,        1, 32'h0,   32'h0};   // SRA
    tbl[10] = '{32'h00002033, 32'h0,        1, 32'h0,   32'h0};   // SLT
    tbl[11] = '{32'h00001023, 32'h0,        1, 32'h0,   32'h0};   // SH
    ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h7F};

    m_valid = 0; m_cmp = 0; m_b = '0; m_instr = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;

    // Reset with traffic present: nothing may be captured or written.
    rst_n = 0; in_valid = 1; instr = 32'hFFD28313; out_ready = 1;
    wb_en = 1; wb_rd = 5'd5; wb_data = 32'hDEAD;
    tick(); tick();
    rst_n = 1; in_valid = 0; wb_en = 0;

    wb(5, 32'h10); wb(2, 32'h100); wb(7, 32'hAB); wb(4, 32'h22);
    wb(0, 32'hFFFF);

    for (int i = 0; i < 12; i++) begin
      instr = tbl[i].instr; in_valid = 1;
      tick();
      chk("tbl_imm", imm, tbl[i].imm);
      chk("tbl_illegal", {31'd0, illegal}, {31'd0, tbl[i].ill});
      chk("tbl_rd1", read_data1, tbl[i].rd1);
      chk("tbl_rd2", read_data2, tbl[i].rd2);
    end
    in_valid = 0; tick();

    // Capture-cycle bypass of rs1.
    instr = 32'h004180B3; in_valid = 1; wb_en = 1; wb_rd = 3; wb_data = 32'h55;
    tick();
    wb_en = 0;
    chk("bypass_rd1", read_data1, 32'h55);

    // Stall three cycles; rs2 written in the second one.
    instr = 32'h004180B3; in_valid = 1; out_ready = 1;
    tick();
    instr = 32'h00000013; out_ready = 0;
    tick();
    chk("stall_rdy", {31'd0, in_ready}, 32'd0);
    wb_en = 1; wb_rd = 4; wb_data = 32'h77;
    tick();
    wb_en = 0;
    chk("snoop_rd2", read_data2, 32'h77);
    tick();
    chk("snoop_hold_rd2", read_data2, 32'h77);
    chk("snoop_hold_rd1", read_data1, 32'h55);
    chk("snoop_hold_op", {25'd0, opcode}, 32'h33);
    out_ready = 1; in_valid = 0;
    tick();

    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = {$urandom_range(0, 32'h1FFFFFF), ops[$urandom_range(0, 4)]};
      wb_en     = $urandom_range(0, 1);
      wb_rd     = $urandom_range(0, 31);
      wb_data   = $urandom;
      tick();
    end
    rst_n = 1; wb_en = 0; in_valid = 0; out_ready = 1;
    tick();

    // Reset during a stall drops the bundle and clears registers.
    wb(5, 32'h10);
    instr = 32'hFFD28313; in_valid = 1;
    tick();
    out_ready = 0; in_valid = 0;
    tick();
    rst_n = 0;
    tick();
    chk("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1; out_ready = 1; in_valid = 1; instr = 32'hFFD28313;
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_x5", read_data1, 32'd0);
    in_valid = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
